coeff_fetch_seq: RTL

Read sequencer that sits directly downstream of the single-port coefficient RAM. It takes a start request with base address and length, drives the RAM's enable/address port, absorbs the RAM's 1-cycle registered read latency, and presents the FP32 coefficient words as a valid/ready stream to the arithmetic datapath. It applies backpressure without dropping or duplicating words, through a 2-entry output buffer.

---
 rtl/coeff_fetch_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/coeff_fetch_seq.sv
// coeff_fetch_seq: read sequencer between the single-port coefficient RAM and
// the arithmetic datapath. Issues RAM reads for a (base, count) request,
// absorbs the one-cycle registered read latency and streams the words out
// through a 2-entry buffer with valid/ready backpressure.
// Optional build macro: COEFF_FETCH_RANGE_CHECK_EN (adds range_err and
// rejects requests that would run past the end of the RAM).
module coeff_fetch_seq #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          count,
    output logic                 busy,
    output logic                 done,
`ifdef COEFF_FETCH_RANGE_CHECK_EN
    output logic                 range_err,
`endif
    output logic                 ram_enable,
    output logic                 ram_write_en,
    output logic [AW-1:0]        ram_address,
    input  logic [MEM_WIDTH-1:0] ram_data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MEM_WIDTH-1:0] out_data,
    output logic                 out_last
);

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [AW-1:0]        addr_reg, addr_next;
    logic [AW:0]          remain_reg, remain_next;
    logic                 pend_reg, pend_next;
    logic                 pend_last_reg, pend_last_next;
    logic [1:0]           occ_reg, occ_next;
    logic [MEM_WIDTH-1:0] buf_data_reg [BUF_DEPTH];
    logic                 buf_last_reg [BUF_DEPTH];

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 start_ok;
    logic [2:0]           inflight;
    logic [1:0]           wr_pos;
    logic [BUF_DEPTH-1:0] wr_sel;
    logic [AW-1:0]        addr_inc;

    // Handshake, push and issue qualification derived from registered state
    assign pop      = out_valid & out_ready;
    assign push     = pend_reg;
    assign inflight = {1'b0, occ_reg} + {2'b0, pend_reg} - {2'b0, pop};
    assign issue    = (state_reg == FETCH) && (inflight < 3'd2);
    assign occ_next = occ_reg + {1'b0, push} - {1'b0, pop};
    assign wr_pos   = occ_reg - {1'b0, pop};
    assign addr_inc = (addr_reg == AW'(MEM_DEPTH - 1)) ? '0 : addr_reg + 1'b1;

`ifdef COEFF_FETCH_RANGE_CHECK_EN
    logic range_bad;
    logic range_err_reg;

    assign range_bad = ({2'b00, base_addr} + {1'b0, count}) > (AW + 2)'(MEM_DEPTH);
    assign start_ok  = (state_reg == IDLE) && start && !range_bad;
    assign range_err = range_err_reg;

    // One-cycle rejection flag for starts that would run past the RAM end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            range_err_reg <= 1'b0;
        end else begin
            range_err_reg <= (state_reg == IDLE) && start && range_bad;
        end
    end
`else
    assign start_ok = (state_reg == IDLE) && start;
`endif

    // Next-state, pointer/counter updates and control outputs
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remain_next    = remain_reg;
        pend_next      = issue;
        pend_last_next = issue && (remain_reg == (AW + 1)'(1));
        busy           = (state_reg != IDLE);
        done           = (state_reg == DONE);
        ram_enable     = issue;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    addr_next   = base_addr;
                    remain_next = count;
                    state_next  = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    addr_next   = addr_inc;
                    remain_next = remain_reg - 1'b1;
                    if (remain_reg == (AW + 1)'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave once the last word is handed off and nothing is in flight
                if (occ_next == 2'd0 && !pend_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, address pointer, issue counter and pending-read tracking
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remain_reg    <= '0;
            pend_reg      <= 1'b0;
            pend_last_reg <= 1'b0;
            occ_reg       <= 2'd0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remain_reg    <= remain_next;
            pend_reg      <= pend_next;
            pend_last_reg <= pend_last_next;
            occ_reg       <= occ_next;
        end
    end

    // Output buffer: entry 0 is the head; a pop shifts entries toward it and
    // a push lands in the first slot left free after any simultaneous pop.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
            assign wr_sel[gi] = push && (wr_pos == 2'(gi));

            // Load incoming RAM word or shift down on pop
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    buf_data_reg[gi] <= '0;
                    buf_last_reg[gi] <= 1'b0;
                end else if (wr_sel[gi]) begin
                    buf_data_reg[gi] <= ram_data_out;
                    buf_last_reg[gi] <= pend_last_reg;
                end else if (pop) begin
                    if (gi < BUF_DEPTH - 1) begin
                        buf_data_reg[gi] <= buf_data_reg[(gi + 1) % BUF_DEPTH];
                        buf_last_reg[gi] <= buf_last_reg[(gi + 1) % BUF_DEPTH];
                    end else begin
                        buf_last_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign ram_write_en = 1'b0;
    assign ram_address  = addr_reg;
    assign out_valid    = (occ_reg != 2'd0);
    assign out_data     = buf_data_reg[0];
    assign out_last     = buf_last_reg[0] && (occ_reg != 2'd0);

endmodule
